// File: rtl/locked_adder_acc.sv
// Key-locked WIDTH-bit ripple-carry adder/accumulator with a serially loaded key
// and valid/ready operand and result handshakes.
module locked_adder_acc #(
   parameter int WIDTH     = 8,
   parameter int KEY_WIDTH = 2*WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_in,
   input  logic             key_shift,
   input  logic             key_clear,
   output logic             key_loaded,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             acc_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = $clog2(KEY_WIDTH + 1);

   if (KEY_WIDTH != 2*WIDTH) begin : g_bad_key_width
      $error("locked_adder_acc: KEY_WIDTH must equal 2*WIDTH");
   end
   if (WIDTH < 2) begin : g_bad_width
      $error("locked_adder_acc: WIDTH must be at least 2");
   end

   typedef enum logic {KEY_LOAD, ACTIVE} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [KEY_WIDTH-1:0] r_key;
   logic [CNT_W-1:0]     r_cnt;
   logic [WIDTH-1:0]     r_acc;
   logic [WIDTH-1:0]     r_sum;
   logic                 r_cout;
   logic                 r_valid;
   logic                 w_accept;
   logic                 w_last_shift;
   logic [WIDTH-1:0]     w_sum;
   logic [WIDTH:0]       w_carry;
   logic                 w_x;
   logic                 w_s;

   assign w_last_shift = key_shift && (r_cnt == CNT_W'(KEY_WIDTH - 1));
   assign key_loaded   = (r_state == ACTIVE);
   assign in_ready     = (r_state == ACTIVE) && (!r_valid || out_ready);
   assign w_accept     = in_valid && in_ready;
   assign out_valid    = r_valid;
   assign sum          = r_sum;
   assign cout         = r_cout;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= KEY_LOAD;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (key_clear) begin
         w_state_nxt = KEY_LOAD;
      end else begin
         unique case (r_state)
            KEY_LOAD: if (w_last_shift) w_state_nxt = ACTIVE;
            ACTIVE:   w_state_nxt = ACTIVE;
            default:  w_state_nxt = KEY_LOAD;
         endcase
      end
   end

   // Even key bits sit on XNOR sum gates, odd key bits on XOR carry gates.
   always_comb begin
      w_carry    = '0;
      w_sum      = '0;
      w_x        = 1'b0;
      w_s        = 1'b0;
      w_carry[0] = cin;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         w_x          = acc_en ? r_acc[i] : a[i];
         w_s          = w_x ^ b[i] ^ w_carry[i];
         w_sum[i]     = ~(w_s ^ r_key[2*i]);
         w_carry[i+1] = ((w_x & b[i]) | (w_x & w_carry[i]) | (b[i] & w_carry[i]))
                        ^ r_key[2*i+1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_key   <= '0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_valid <= 1'b0;
      end else if (key_clear) begin
         r_key   <= '0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_valid <= 1'b0;
      end else begin
         if ((r_state == KEY_LOAD) && key_shift) begin
            r_key <= {r_key[KEY_WIDTH-2:0], key_in};
            r_cnt <= r_cnt + 1'b1;
         end
         // Accept wins over pop so a simultaneous pop+accept keeps out_valid high.
         if (w_accept) begin
            r_sum   <= w_sum;
            r_cout  <= w_carry[WIDTH];
            r_acc   <= w_sum;
            r_valid <= 1'b1;
         end else if (out_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

endmodule
